// File: rtl/trigger_scheduler_pkg.sv
// Shared types and constants for the trigger scheduler.
package trigger_scheduler_pkg;

  // Offer/holdoff sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  // cfg_wdata field positions
  localparam int unsigned ENABLE_BIT   = 0;
  localparam int unsigned POLARITY_BIT = 1;

  // Per-channel edge_detect value after reset (rising edge)
  localparam logic EDGE_DETECT_RST = 1'b1;

  // Cycles edge_in is ignored after a config write, write cycle included
  localparam int unsigned SETTLE_LEN = 3;
  localparam int unsigned SETTLE_W   = $clog2(SETTLE_LEN);

endpackage

// File: rtl/trigger_scheduler_rr_picker.sv
// Round-robin picker: first set bit of i_pending at or after i_rr_ptr,
// wrapping at CHANNELS (which need not be a power of two).
module trigger_scheduler_rr_picker #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CH_W     = 2
) (
  input  logic [CHANNELS-1:0] i_pending,
  input  logic [CH_W-1:0]     i_rr_ptr,
  output logic                o_found,
  output logic [CH_W-1:0]     o_index
);

  int unsigned w_j;

  // Scan CHANNELS positions starting at the pointer, keep the first hit
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_j     = 0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_j = 32'(i_rr_ptr) + k;
      if (w_j >= CHANNELS) begin
        w_j = w_j - CHANNELS;
      end
      if (!o_found && (((i_pending >> w_j) & CHANNELS'(1)) != '0)) begin
        o_found = 1'b1;
        o_index = CH_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/trigger_scheduler.sv
// Trigger scheduler: captures conditioner edge pulses into one pending slot
// per channel and offers them one at a time, round-robin, with holdoff.
module trigger_scheduler
  import trigger_scheduler_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CH_W      = 2,
  parameter int unsigned HOLDOFF_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  edge_in,
  output logic [CHANNELS-1:0]  edge_detect,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_addr,
  input  logic [1:0]           cfg_wdata,
  input  logic [HOLDOFF_W-1:0] holdoff,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [CH_W-1:0]      event_channel,
  output logic [CHANNELS-1:0]  overflow,
  input  logic                 clear_overflow
);

  logic [CHANNELS-1:0]  r_enable;
  logic [CHANNELS-1:0]  r_edge_detect;
  logic [CHANNELS-1:0]  r_pending;
  logic [CHANNELS-1:0]  r_overflow;
  logic [SETTLE_W-1:0]  r_settle [CHANNELS];

  state_e               r_state;
  logic                 r_event_valid;
  logic [CH_W-1:0]      r_event_channel;
  logic [CH_W-1:0]      r_rr_ptr;
  logic [HOLDOFF_W-1:0] r_hcnt;

  logic [CHANNELS-1:0]  w_cfg_hit;
  logic [CHANNELS-1:0]  w_mask;
  logic [CHANNELS-1:0]  w_capture;
  logic [CHANNELS-1:0]  w_pick_vec;
  logic [CHANNELS-1:0]  w_pend_keep;
  logic [CHANNELS-1:0]  w_ovf_set;
  logic [CHANNELS-1:0]  w_pending_nxt;
  logic [CHANNELS-1:0]  w_overflow_nxt;
  logic                 w_found;
  logic [CH_W-1:0]      w_pick_idx;
  logic                 w_pick_take;
  logic [CH_W:0]        w_ch_inc;
  logic [CH_W-1:0]      w_rr_inc;

  state_e               w_state_nxt;
  logic                 w_valid_nxt;
  logic [CH_W-1:0]      w_ch_nxt;
  logic [CH_W-1:0]      w_rr_nxt;
  logic [HOLDOFF_W-1:0] w_hcnt_nxt;

  trigger_scheduler_rr_picker #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_rr_picker (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_found   (w_found),
    .o_index   (w_pick_idx)
  );

  // Config address decode and settle masking (out-of-range addresses hit nothing)
  always_comb begin
    w_cfg_hit = '0;
    w_mask    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cfg_hit[i] = cfg_we && (cfg_addr == CH_W'(i));
      w_mask[i]    = w_cfg_hit[i] || (r_settle[i] != '0);
    end
  end

  assign w_capture  = edge_in & r_enable & ~w_mask;
  assign w_pick_vec = w_pick_take ? (CHANNELS'(1) << w_pick_idx) : '0;

  // Pending/overflow update; a channel being picked this cycle is no longer
  // pending, so an edge on it re-arms without counting as an overflow
  always_comb begin
    w_pend_keep    = r_pending & ~w_pick_vec;
    w_ovf_set      = w_capture & w_pend_keep;
    w_pending_nxt  = w_pend_keep | w_capture;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_cfg_hit[i] && !cfg_wdata[ENABLE_BIT]) begin
        w_pending_nxt[i] = 1'b0;
      end
    end
    w_overflow_nxt = (clear_overflow ? '0 : r_overflow) | w_ovf_set;
  end

  // Per-channel configuration, settle counters, pending and overflow state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable      <= '0;
      r_edge_detect <= {CHANNELS{EDGE_DETECT_RST}};
      r_pending     <= '0;
      r_overflow    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_settle[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_cfg_hit[i]) begin
          r_enable[i]      <= cfg_wdata[ENABLE_BIT];
          r_edge_detect[i] <= cfg_wdata[POLARITY_BIT];
          r_settle[i]      <= SETTLE_W'(SETTLE_LEN - 1);
        end else if (r_settle[i] != '0) begin
          r_settle[i]      <= r_settle[i] - SETTLE_W'(1);
        end
      end
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  // Round-robin pointer advance past the accepted channel
  assign w_ch_inc = {1'b0, r_event_channel} + (CH_W + 1)'(1);
  assign w_rr_inc = (w_ch_inc >= (CH_W + 1)'(CHANNELS)) ? '0 : w_ch_inc[CH_W-1:0];

  // Sequencer next-state and registered-output values
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_event_valid;
    w_ch_nxt    = r_event_channel;
    w_rr_nxt    = r_rr_ptr;
    w_hcnt_nxt  = r_hcnt;
    w_pick_take = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_pick_take = 1'b1;
          w_ch_nxt    = w_pick_idx;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (event_ready) begin
          w_valid_nxt = 1'b0;
          w_rr_nxt    = w_rr_inc;
          if (holdoff == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_hcnt_nxt  = holdoff;
            w_state_nxt = ST_HOLDOFF;
          end
        end
      end
      ST_HOLDOFF: begin
        w_hcnt_nxt = r_hcnt - HOLDOFF_W'(1);
        if (r_hcnt == HOLDOFF_W'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_event_valid   <= 1'b0;
      r_event_channel <= '0;
      r_rr_ptr        <= '0;
      r_hcnt          <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_event_valid   <= w_valid_nxt;
      r_event_channel <= w_ch_nxt;
      r_rr_ptr        <= w_rr_nxt;
      r_hcnt          <= w_hcnt_nxt;
    end
  end

  assign edge_detect   = r_edge_detect;
  assign event_valid   = r_event_valid;
  assign event_channel = r_event_channel;
  assign overflow      = r_overflow;

endmodule
